ballot_input_conditioner: RTL and testbench

- Front-end stage feeding the voting machine core: synchronises and debounces the four raw candidate buttons and the mode switch.
- Enforces one action per press and rejects multi-button presses.
- Emits single-cycle, one-hot vote or result-query strobes that the core's tally/display logic consumes directly.

---
 rtl/ballot_input_conditioner.sv | 153 +++++++++++++++
 tb/tb_ballot_input_conditioner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ballot_input_conditioner.sv
// Button/mode front end for the voting core: synchronise, debounce, enforce a single
// press per action and emit one-hot vote, query or reject strobes.
module ballot_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 10,
  parameter int unsigned LOCKOUT_CYCLES  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       button4,
  output logic       vote_valid,
  output logic       query_valid,
  output logic [3:0] cand_sel,
  output logic       reject,
  output logic       busy
);

  localparam int unsigned NB    = 4;
  localparam int unsigned CNT_W = 8;
  // Last count value before the qualifying / releasing edge.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE,
    QUAL,
    FIRE,
    REJECT,
    WAIT_REL
  } state_t;

  logic [NB-1:0]    btn_m, btn_s;
  logic             mode_m, mode_s;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic [NB-1:0]    cand_q, cand_nx;
  logic             mode_q, mode_nx;
  logic             single_btn;

  logic             vote_nx, query_nx, reject_nx, busy_nx;
  logic [NB-1:0]    cand_sel_nx;

  // Two-flop synchronisers; only btn_s/mode_s reach the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_m  <= '0;
      btn_s  <= '0;
      mode_m <= 1'b0;
      mode_s <= 1'b0;
    end else begin
      btn_m  <= {button4, button3, button2, button1};
      btn_s  <= btn_m;
      mode_m <= mode;
      mode_s <= mode_m;
    end
  end

  assign single_btn = (btn_s != '0) && ((btn_s & (btn_s - NB'(1))) == '0);
  assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cand_q      <= '0;
      mode_q      <= 1'b0;
      vote_valid  <= 1'b0;
      query_valid <= 1'b0;
      cand_sel    <= '0;
      reject      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      cand_q      <= cand_nx;
      mode_q      <= mode_nx;
      vote_valid  <= vote_nx;
      query_valid <= query_nx;
      cand_sel    <= cand_sel_nx;
      reject      <= reject_nx;
      busy        <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand_q;
    mode_nx  = mode_q;

    case (state)
      IDLE: begin
        if (btn_s != '0) begin
          if (single_btn) begin
            cand_nx  = btn_s;
            mode_nx  = mode_s;
            cnt_nx   = CNT_W'(1);
            state_nx = QUAL;
          end else begin
            state_nx = REJECT;
          end
        end
      end
      QUAL: begin
        if (btn_s == '0) begin
          state_nx = IDLE;
        end else if (btn_s != cand_q) begin
          state_nx = REJECT;
        end else if (mode_s != mode_q) begin
          cnt_nx   = '0;
          state_nx = WAIT_REL;
        end else if (cnt >= DEB_LAST) begin
          mode_nx  = mode_s;
          state_nx = FIRE;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      FIRE, REJECT: begin
        cnt_nx   = '0;
        state_nx = WAIT_REL;
      end
      WAIT_REL: begin
        // Any activity restarts the all-released lockout window.
        if (btn_s != '0) begin
          cnt_nx = '0;
        end else if (cnt >= LOCK_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    vote_nx     = (state_nx == FIRE) && !mode_nx;
    query_nx    = (state_nx == FIRE) && mode_nx;
    cand_sel_nx = (state_nx == FIRE) ? cand_nx : '0;
    reject_nx   = (state_nx == REJECT);
    busy_nx     = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_ballot_input_conditioner.sv
// Scoreboard bench for ballot_input_conditioner: directed presses queue expected strobes,
// a negedge monitor pops and compares kind, candidate and arrival cycle.
module tb_ballot_input_conditioner;

  localparam int DEB      = 10;
  localparam int LOCK     = 16;
  localparam int LAT      = DEB + 2;  // drive cycle to strobe cycle
  localparam int REJ_LAT  = 3;
  localparam int K_VOTE   = 0;
  localparam int K_QUERY  = 1;
  localparam int K_REJ    = 2;

  typedef struct {
    int         kind;
    logic [3:0] cand;
    int         at;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       mode;
  logic       button1, button2, button3, button4;
  logic       vote_valid, query_valid, reject, busy;
  logic [3:0] cand_sel;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  exp_t sb[$];

  ballot_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .LOCKOUT_CYCLES (LOCK)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mode       (mode),
    .button1    (button1),
    .button2    (button2),
    .button3    (button3),
    .button4    (button4),
    .vote_valid (vote_valid),
    .query_valid(query_valid),
    .cand_sel   (cand_sel),
    .reject     (reject),
    .busy       (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] b);
    {button4, button3, button2, button1} = b;
  endtask

  task automatic push(input int kind, input logic [3:0] cand, input int at);
    exp_t e;
    e.kind = kind;
    e.cand = cand;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Busy must stay high through the 16th released cycle and drop on the next.
  task automatic wait_release(input string name, input int rel);
    tick(rel + LOCK + 1 - cyc);
    check({name, "_busy_lockout"}, int'(busy), 1);
    tick(1);
    check({name, "_busy_idle"}, int'(busy), 0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_vote"},  int'(vote_valid),  0);
    check({name, "_query"}, int'(query_valid), 0);
    check({name, "_rej"},   int'(reject),      0);
    check({name, "_cand"},  int'(cand_sel),    0);
    check({name, "_busy"},  int'(busy),        0);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  initial begin
    exp_t e;
    int   kind;
    forever begin
      @(negedge clock);
      if (vote_valid || query_valid || reject) begin
        check("strobe_exclusive", int'(vote_valid) + int'(query_valid) + int'(reject), 1);
        kind = vote_valid ? K_VOTE : (query_valid ? K_QUERY : K_REJ);
        if (sb.size() == 0) begin
          check("unexpected_strobe_kind", kind, -1);
        end else begin
          e = sb.pop_front();
          check("strobe_kind",  kind,           e.kind);
          check("strobe_cand",  int'(cand_sel), int'(e.cand));
          check("strobe_cycle", cyc,            e.at);
        end
      end else if (cand_sel != 4'b0000) begin
        check("idle_cand_sel", int'(cand_sel), 0);
      end
    end
  end

  initial begin
    int p, r, d;
    reset = 1'b1;
    mode  = 1'b0;
    set_btn(4'b0000);
    tick(20);
    check_quiet("reset");
    reset = 1'b0;
    tick(3);

    // Single clean press of button1.
    p = cyc;
    set_btn(4'b0001);
    push(K_VOTE, 4'b0001, p + LAT);
    tick(5);
    check("t1_busy_qual", int'(busy), 1);
    tick(p + 20 - cyc);
    set_btn(4'b0000);
    r = cyc;
    wait_release("t1", r);
    tick(3);

    // One-cycle glitch, gap, then a real press.
    set_btn(4'b0001);
    tick(1);
    set_btn(4'b0000);
    tick(1);
    set_btn(4'b0001);
    p = cyc;
    push(K_VOTE, 4'b0001, p + LAT);
    tick(20);
    set_btn(4'b0000);
    r = cyc;
    wait_release("t2", r);
    tick(3);

    // Two buttons together.
    p = cyc;
    set_btn(4'b0110);
    push(K_REJ, 4'b0000, p + REJ_LAT);
    tick(20);
    check("t3_busy_held", int'(busy), 1);
    set_btn(4'b0000);
    r = cyc;
    wait_release("t3", r);
    tick(3);

    // Result query, mode flip after fire, then a vote.
    mode = 1'b1;
    tick(4);
    p = cyc;
    set_btn(4'b0010);
    push(K_QUERY, 4'b0010, p + LAT);
    tick(15);
    mode = 1'b0;
    tick(5);
    set_btn(4'b0000);
    r = cyc;
    wait_release("t4a", r);
    tick(2);
    p = cyc;
    set_btn(4'b0100);
    push(K_VOTE, 4'b0100, p + LAT);
    tick(20);
    set_btn(4'b0000);
    r = cyc;
    wait_release("t4b", r);
    tick(3);

    // Long hold, then re-press inside the lockout window.
    p = cyc;
    set_btn(4'b1000);
    push(K_VOTE, 4'b1000, p + LAT);
    tick(100);
    set_btn(4'b0000);
    tick(5);
    set_btn(4'b1000);
    tick(10);
    check("t5_busy_repress", int'(busy), 1);
    set_btn(4'b0000);
    r = cyc;
    wait_release("t5", r);
    tick(3);

    // Reset in the middle of qualification (cnt = 6).
    p = cyc;
    set_btn(4'b0001);
    tick(8);
    reset = 1'b1;
    tick(3);
    check_quiet("t6_reset");
    reset = 1'b0;
    d = cyc;
    push(K_VOTE, 4'b0001, d + LAT);
    tick(20);
    set_btn(4'b0000);
    r = cyc;
    wait_release("t6", r);
    tick(5);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
